ibuf2ddr: RTL and testbench

- Reads the sparse-index buffer of one selected PE and streams it back to DDR as packed DDR_W words on a valid/ready interface.
- It is the drain/readback counterpart of the DDR-to-index-buffer loader; it sits between the PE index buffers' read ports and the DDR write stream.
- Used for checkpointing and debug readback of index tables.
- Uses the same packing convention as the loader: IDX_BATCH index pairs per word, lane 0 in the LSBs, optional half-swap.

---
 rtl/ibuf2ddr_pkg.sv | 28 ++
 rtl/ibuf2ddr_if.sv | 11 +
 rtl/ibuf2ddr_idx_packer.sv | 112 +++++++++++
 rtl/ibuf2ddr.sv | 135 +++++++++++++
 tb/tb_ibuf2ddr.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ibuf2ddr_pkg.sv
// Shared widths, helpers and constants for the index-buffer readback path.
// The swap constant is the same one the DDR-to-index-buffer loader uses.
package ibuf2ddr_pkg;

  localparam int DDR_W = 64;
  localparam int IDX_W = 8;

  // Number of bits needed to address n items (at least 1).
  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Index pairs that fit in one DDR word.
  function automatic int idx_batch(input int ddr_w, input int idx_w);
    return ddr_w / (idx_w * 2);
  endfunction

  // conf_mode[2:1] value that exchanges the two IDX_W halves of every entry.
  localparam logic [1:0] IBUF_SWAP_MODE = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_FLUSH,
    ST_DONE
  } ibuf_state_e;

endpackage

// File: rtl/ibuf2ddr_if.sv
// Valid/ready stream carrying packed index words towards DDR.
interface ibuf2ddr_if #(
  parameter int DDR_W = ibuf2ddr_pkg::DDR_W
);
  logic [DDR_W-1:0] ddr_data;
  logic             ddr_valid;
  logic             ddr_ready;

  modport master (output ddr_data, output ddr_valid, input ddr_ready);
  modport slave  (input ddr_data, input ddr_valid, output ddr_ready);
endinterface

// File: rtl/ibuf2ddr_idx_packer.sv
// Packs a stream of index entries into DDR words, lane 0 in the LSBs, behind a
// one-word output register. The pack register doubles as a second word slot.
module ibuf2ddr_idx_packer
  import ibuf2ddr_pkg::*;
#(
  parameter int DDR_W = ibuf2ddr_pkg::DDR_W,
  parameter int EW    = 2 * ibuf2ddr_pkg::IDX_W,
  parameter int BATCH = idx_batch(DDR_W, EW / 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [EW-1:0]    in_entry,
  input  logic             in_last,
  output logic [DDR_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             full_next
);

  localparam int CW = bw(BATCH);

  logic [DDR_W-1:0] pack_data_q, pack_data_d;
  logic [CW-1:0]    pack_cnt_q, pack_cnt_d;
  logic             pack_full_q, pack_full_d;
  logic             pack_last_q, pack_last_d;
  logic [DDR_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [DDR_W-1:0] merged;
  logic             out_take;
  logic             word_done;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    pack_data_d = pack_data_q;
    pack_cnt_d  = pack_cnt_q;
    pack_full_d = pack_full_q;
    pack_last_d = pack_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    merged = pack_data_q;
    for (int j = 0; j < BATCH; j++) begin
      if (pack_cnt_q == CW'(j)) merged[j*EW +: EW] = in_entry;
    end

    out_take  = !out_valid_q || out_ready;
    word_done = in_valid && (in_last || pack_cnt_q == CW'(BATCH - 1));

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    // A full pack register blocks new entries; the read side never sends one then.
    if (pack_full_q) begin
      if (out_take) begin
        out_data_d  = pack_data_q;
        out_valid_d = 1'b1;
        out_last_d  = pack_last_q;
        pack_data_d = '0;
        pack_full_d = 1'b0;
        pack_last_d = 1'b0;
      end
    end else if (in_valid) begin
      if (word_done) begin
        pack_cnt_d = '0;
        if (out_take) begin
          out_data_d  = merged;
          out_valid_d = 1'b1;
          out_last_d  = in_last;
          pack_data_d = '0;
        end else begin
          pack_data_d = merged;
          pack_full_d = 1'b1;
          pack_last_d = in_last;
        end
      end else begin
        pack_data_d = merged;
        pack_cnt_d  = pack_cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_data_q <= '0;
      pack_cnt_q  <= '0;
      pack_full_q <= 1'b0;
      pack_last_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      pack_data_q <= pack_data_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_full_q <= pack_full_d;
      pack_last_q <= pack_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign full_next = pack_full_d;

endmodule

// File: rtl/ibuf2ddr.sv
// Drains one PE's index buffer to DDR: reads entries 0..n-1 and streams them
// out packed IDX_BATCH per word, optionally half-swapped.
module ibuf2ddr
  import ibuf2ddr_pkg::*;
#(
  parameter int DDR_W     = ibuf2ddr_pkg::DDR_W,
  parameter int IDX_W     = ibuf2ddr_pkg::IDX_W,
  parameter int IDX_DEPTH = 256,
  parameter int ADDR_W    = bw(IDX_DEPTH),
  parameter int PE_NUM    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      done,
  input  logic [3:0]                conf_mode,
  input  logic [7:0]                conf_idx_num,
  input  logic [bw(PE_NUM)-1:0]     conf_pe_sel,
  output logic [ADDR_W-1:0]         idx_rd_addr,
  output logic                      idx_rd_en,
  input  logic [PE_NUM*IDX_W*2-1:0] idx_rd_data,
  ibuf2ddr_if.master                ddr
);

  localparam int EW        = 2 * IDX_W;
  localparam int IDX_BATCH = idx_batch(DDR_W, IDX_W);
  localparam int PSW       = bw(PE_NUM);

  ibuf_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        num_q, num_d;
  logic [PSW-1:0]    pe_sel_q, pe_sel_d;
  logic              swap_q, swap_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;

  logic              last_addr;
  logic              full_next;
  logic              out_last;
  logic              last_hs;
  logic [EW-1:0]     entry_raw;
  logic [EW-1:0]     entry;

  logic unused_mode;
  assign unused_mode = ^{conf_mode[3], conf_mode[0]};

  assign last_addr = (addr_q == ADDR_W'(num_q - 8'd1));
  assign last_hs   = ddr.ddr_valid && ddr.ddr_ready && out_last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (conf_idx_num != 8'd0) ? ST_READ : ST_DONE;
      ST_READ:  if (idx_rd_en && last_addr) state_d = ST_FLUSH;
      ST_FLUSH: if (last_hs) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read only when the entry returning next cycle is sure to find a free slot.
  always_comb begin
    idx_rd_en = (state_q == ST_READ) && !full_next;
    done      = (state_q == ST_DONE);
  end

  always_comb begin
    addr_d    = addr_q;
    num_d     = num_q;
    pe_sel_d  = pe_sel_q;
    swap_d    = swap_q;
    rd_vld_d  = idx_rd_en;
    rd_last_d = idx_rd_en && last_addr;
    if (state_q == ST_IDLE && start) begin
      addr_d   = '0;
      num_d    = conf_idx_num;
      pe_sel_d = conf_pe_sel;
      swap_d   = (conf_mode[2:1] == IBUF_SWAP_MODE);
    end else if (idx_rd_en) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      num_q     <= '0;
      pe_sel_q  <= '0;
      swap_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      num_q     <= num_d;
      pe_sel_q  <= pe_sel_d;
      swap_q    <= swap_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
    end
  end

  // Lane select by loop keeps out-of-range PE selects at zero data.
  always_comb begin
    entry_raw = '0;
    for (int p = 0; p < PE_NUM; p++) begin
      if (int'(pe_sel_q) == p) entry_raw = idx_rd_data[p*EW +: EW];
    end
    entry = swap_q ? {entry_raw[IDX_W-1:0], entry_raw[EW-1:IDX_W]} : entry_raw;
  end

  assign idx_rd_addr = addr_q;

  ibuf2ddr_idx_packer #(
    .DDR_W (DDR_W),
    .EW    (EW),
    .BATCH (IDX_BATCH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_vld_q),
    .in_entry  (entry),
    .in_last   (rd_last_q),
    .out_data  (ddr.ddr_data),
    .out_valid (ddr.ddr_valid),
    .out_ready (ddr.ddr_ready),
    .out_last  (out_last),
    .full_next (full_next)
  );

endmodule

// File: tb/tb_ibuf2ddr.sv
// Randomized bench for ibuf2ddr: a memory model answers reads, and expected
// words are built directly from the buffer contents and the packing rule.
module tb_ibuf2ddr;

  localparam int DDR_W  = 64;
  localparam int IDX_W  = 8;
  localparam int EW     = 2 * IDX_W;
  localparam int BATCH  = DDR_W / EW;
  localparam int PE_NUM = 20;
  localparam int PSW    = 5;
  localparam int DEPTH  = 256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 done;
  logic [3:0]           conf_mode = '0;
  logic [7:0]           conf_idx_num = '0;
  logic [PSW-1:0]       conf_pe_sel = '0;
  logic [7:0]           idx_rd_addr;
  logic                 idx_rd_en;
  logic [PE_NUM*EW-1:0] idx_rd_data = '0;

  ibuf2ddr_if #(.DDR_W(DDR_W)) ddr_if ();

  ibuf2ddr #(
    .DDR_W     (DDR_W),
    .IDX_W     (IDX_W),
    .IDX_DEPTH (DEPTH),
    .PE_NUM    (PE_NUM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done         (done),
    .conf_mode    (conf_mode),
    .conf_idx_num (conf_idx_num),
    .conf_pe_sel  (conf_pe_sel),
    .idx_rd_addr  (idx_rd_addr),
    .idx_rd_en    (idx_rd_en),
    .idx_rd_data  (idx_rd_data),
    .ddr          (ddr_if.master)
  );

  always #5 clk = ~clk;

  logic [EW-1:0]    mem [PE_NUM][DEPTH];
  logic [DDR_W-1:0] exp_q[$];
  logic [DDR_W-1:0] got_words[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int duty = 100;
  bit mon_en = 1'b0;
  bit rd_seen = 1'b0;
  logic [7:0] rd_addr_seen = '0;
  bit prev_stall = 1'b0;
  logic [DDR_W-1:0] prev_data = '0;
  int exp_addr, rd_cnt, hs_cnt, vld_cnt, done_cnt;
  int first_rd_cyc, first_vld_cyc, last_hs_cyc, done_cyc, start_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [PE_NUM*EW-1:0] mem_bus(input logic [7:0] a);
    logic [PE_NUM*EW-1:0] b;
    for (int p = 0; p < PE_NUM; p++) b[p*EW +: EW] = mem[p][a];
    return b;
  endfunction

  function automatic logic [PE_NUM*EW-1:0] rand_bus();
    logic [PE_NUM*EW-1:0] b;
    for (int p = 0; p < PE_NUM; p++) b[p*EW +: EW] = EW'($urandom);
    return b;
  endfunction

  // Expected words straight from the packing rule: entry k -> word k/B, lane k%B.
  task automatic build_expected(input int n, input int pe, input logic [3:0] mode);
    logic [DDR_W-1:0] w;
    logic [EW-1:0] e;
    exp_q.delete();
    for (int wi = 0; wi < (n + BATCH - 1) / BATCH; wi++) begin
      w = '0;
      for (int j = 0; j < BATCH; j++) begin
        int k = wi * BATCH + j;
        if (k < n) begin
          e = (pe < PE_NUM) ? mem[pe][k] : '0;
          if (mode[2:1] == 2'b01) e = {e[IDX_W-1:0], e[EW-1:IDX_W]};
          w = w | (DDR_W'(e) << (EW * j));
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_counters();
    exp_addr = 0; rd_cnt = 0; hs_cnt = 0; vld_cnt = 0; done_cnt = 0;
    first_rd_cyc = -1; first_vld_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    got_words.delete();
  endtask

  task automatic monitor();
    logic [DDR_W-1:0] exp_w;
    rd_seen = 1'b0;
    if (!mon_en) return;
    rd_seen = idx_rd_en;
    rd_addr_seen = idx_rd_addr;
    if (idx_rd_en) begin
      check("rd_addr", 64'(idx_rd_addr), 64'(exp_addr));
      if (rd_cnt == 0) first_rd_cyc = cyc;
      exp_addr++;
      rd_cnt++;
    end
    if (prev_stall) begin
      check("vld_hold", 64'(ddr_if.ddr_valid), 64'd1);
      check("data_hold", ddr_if.ddr_data, prev_data);
    end
    if (ddr_if.ddr_valid) begin
      if (vld_cnt == 0) first_vld_cyc = cyc;
      vld_cnt++;
    end
    if (ddr_if.ddr_valid && ddr_if.ddr_ready) begin
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      check("word", ddr_if.ddr_data, exp_w);
      got_words.push_back(ddr_if.ddr_data);
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = ddr_if.ddr_valid && !ddr_if.ddr_ready;
    prev_data  = ddr_if.ddr_data;
  endtask

  // Sample at the falling edge, drive just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    idx_rd_data = rd_seen ? mem_bus(rd_addr_seen) : rand_bus();
    ddr_if.ddr_ready = ($urandom_range(0, 99) < duty);
    start = 1'b0;
  endtask

  task automatic run_job(input int n, input int pe, input logic [3:0] mode,
                         input int duty_in, input int restart_at);
    duty = duty_in;
    tick();
    build_expected(n, pe, mode);
    clear_counters();
    conf_idx_num = 8'(n);
    conf_pe_sel  = PSW'(pe);
    conf_mode    = mode;
    start        = 1'b1;
    start_cyc    = cyc;
    tick();
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      conf_idx_num = 8'($urandom);
      conf_pe_sel  = PSW'($urandom);
      conf_mode    = 4'($urandom);
      if (i == restart_at) start = 1'b1;
      tick();
    end
    check("done_seen", 64'(done_cnt), 64'd1);
    tick();
    check("done_once", 64'(done_cnt), 64'd1);
    check("rd_count", 64'(rd_cnt), 64'(n));
    check("word_count", 64'(hs_cnt), 64'((n + BATCH - 1) / BATCH));
    check("words_left", 64'(exp_q.size()), 64'd0);
    if (n == 0) begin
      check("zero_done_lat", 64'(done_cyc), 64'(start_cyc + 1));
      check("zero_no_vld", 64'(vld_cnt), 64'd0);
    end else begin
      check("done_lat", 64'(done_cyc), 64'(last_hs_cyc + 1));
      if (duty_in >= 100) begin
        check("first_rd_lat", 64'(first_rd_cyc), 64'(start_cyc + 1));
        check("first_vld_lat", 64'(first_vld_cyc), 64'(start_cyc + BATCH + 2));
      end
    end
  endtask

  initial begin
    ddr_if.ddr_ready = 1'b1;
    for (int p = 0; p < PE_NUM; p++)
      for (int k = 0; k < DEPTH; k++)
        mem[p][k] = (p == 3) ? {8'(k + 16), 8'(k)} : EW'($urandom);

    repeat (3) tick();
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(ddr_if.ddr_valid), 64'd0);
    check("rst_rd_en", 64'(idx_rd_en), 64'd0);
    check("rst_rd_addr", 64'(idx_rd_addr), 64'd0);
    check("rst_data", ddr_if.ddr_data, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    clear_counters();

    run_job(8, 3, 4'b0000, 100, -1);
    check("t1_word0", got_words.size() > 0 ? got_words[0] : 64'h0, 64'h1303_1202_1101_1000);
    check("t1_word1", got_words.size() > 1 ? got_words[1] : 64'h0, 64'h1707_1606_1505_1404);

    run_job(8, 3, 4'b0010, 100, -1);
    check("t2_word0", got_words.size() > 0 ? got_words[0] : 64'h0, 64'h0313_0212_0111_0010);

    run_job(5, 3, 4'b0000, 100, -1);
    check("t3_word1", got_words.size() > 1 ? got_words[1] : 64'hFFFF, 64'h0000_0000_0000_1404);

    run_job(255, $urandom_range(0, PE_NUM - 1), 4'($urandom), 30, -1);

    run_job(0, 3, 4'b0000, 100, -1);
    run_job(8, 3, 4'b0000, 100, 3);

    run_job(9, 25, 4'b0000, 60, -1);

    repeat (3) run_job($urandom_range(1, 255), $urandom_range(0, PE_NUM - 1),
                       4'($urandom), $urandom_range(20, 100), -1);

    // Abort a long job mid-stream, then check a fresh job starts cleanly.
    duty = 100;
    tick();
    build_expected(255, 3, 4'b0000);
    clear_counters();
    conf_idx_num = 8'd255;
    conf_pe_sel  = PSW'(3);
    conf_mode    = 4'b0000;
    start        = 1'b1;
    tick();
    for (int i = 0; i < 2000 && hs_cnt < 3; i++) tick();
    check("abort_reached", 64'(hs_cnt), 64'd3);
    rst = 1'b1;
    tick();
    check("abort_valid", 64'(ddr_if.ddr_valid), 64'd0);
    check("abort_rd_en", 64'(idx_rd_en), 64'd0);
    check("abort_rd_addr", 64'(idx_rd_addr), 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    rst = 1'b0;
    prev_stall = 1'b0;
    run_job(4, 3, 4'b0000, 100, -1);
    check("t6_word0", got_words.size() > 0 ? got_words[0] : 64'h0, 64'h1303_1202_1101_1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
